// File: rtl/clock_edit_ctrl.sv
// clock_edit_ctrl: button conditioning, seconds prescaler and RUN/EDIT
// control for the century clock counter chain.
module clock_edit_ctrl #(
    parameter int NUM_FIELDS      = 6,
    parameter int SEL_W           = 3,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TICK_DIV        = 50000000,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_mode,
    input  logic                  btn_up,
    input  logic                  btn_down,
    output logic                  tick_o,
    output logic                  edit_o,
    output logic [SEL_W-1:0]      sel_o,
    output logic [NUM_FIELDS-1:0] up_o,
    output logic [NUM_FIELDS-1:0] down_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [DW-1:0]    DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]    PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]    TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_FIELDS - 1);

    typedef enum logic {
        RUN  = 1'b0,
        EDIT = 1'b1
    } state_e;

    // Button vectors are packed as {down, up, mode}.
    logic [2:0]         sync1_q, sync1_d;
    logic [2:0]         sync2_q, sync2_d;
    logic [2:0]         stable_q, stable_d;
    logic [2:0]         prev_q, prev_d;
    logic [2:0][DW-1:0] cnt_q, cnt_d;
    logic [2:0]         press;

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  tick_q, tick_d;
    logic [NUM_FIELDS-1:0] up_q, up_d;
    logic [NUM_FIELDS-1:0] down_q, down_d;
    logic [NUM_FIELDS-1:0] sel_hot;

    // Synchronize raw buttons and accept a level only after it holds steady.
    always_comb begin
        sync1_d  = {btn_down, btn_up, btn_mode};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        prev_d   = stable_q;
        for (int b = 0; b < 3; b++) begin
            if (sync2_q[b] == stable_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == DB_MAX) begin
                stable_d[b] = sync2_q[b];
                cnt_d[b]    = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + DW'(1);
            end
        end
    end

    assign press   = stable_q & ~prev_q;
    assign sel_hot = NUM_FIELDS'(1) << sel_q;

    // RUN/EDIT next state, prescaler, timeout and registered pulse outputs.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        presc_d = presc_q;
        tmo_d   = tmo_q;
        tick_d  = 1'b0;
        up_d    = '0;
        down_d  = '0;
        unique case (state_q)
            RUN: begin
                sel_d   = '0;
                tmo_d   = '0;
                tick_d  = (presc_q == PRE_MAX);
                presc_d = tick_d ? '0 : presc_q + PW'(1);
                if (press[0]) begin
                    state_d = EDIT;
                    presc_d = '0;
                end
            end
            EDIT: begin
                presc_d = '0;
                if (|press) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_MAX) begin
                    state_d = RUN;
                    sel_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (press[0]) begin
                    if (sel_q == SEL_MAX) begin
                        state_d = RUN;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end else if (press[1] && !press[2]) begin
                    up_d = sel_hot;
                end else if (press[2] && !press[1]) begin
                    down_d = sel_hot;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // All state and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
            sel_q    <= '0;
            presc_q  <= '0;
            tmo_q    <= '0;
            tick_q   <= 1'b0;
            up_q     <= '0;
            down_q   <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            sel_q    <= sel_d;
            presc_q  <= presc_d;
            tmo_q    <= tmo_d;
            tick_q   <= tick_d;
            up_q     <= up_d;
            down_q   <= down_d;
        end
    end

    assign tick_o = tick_q;
    assign edit_o = (state_q == EDIT);
    assign sel_o  = sel_q;
    assign up_o   = up_q;
    assign down_o = down_q;

endmodule

// File: tb/tb_clock_edit_ctrl.sv
// tb_clock_edit_ctrl: directed scenarios plus random button activity,
// compared cycle by cycle against a behavioural model of the control block.
module tb_clock_edit_ctrl;

    localparam int NF = 6;
    localparam int SW = 3;
    localparam int DB = 4;
    localparam int TD = 10;
    localparam int TO = 150;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_mode = 1'b0;
    logic          btn_up = 1'b0;
    logic          btn_down = 1'b0;
    logic          tick_o;
    logic          edit_o;
    logic [SW-1:0] sel_o;
    logic [NF-1:0] up_o;
    logic [NF-1:0] down_o;

    clock_edit_ctrl #(
        .NUM_FIELDS(NF),
        .SEL_W(SW),
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV(TD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_mode(btn_mode),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .tick_o(tick_o),
        .edit_o(edit_o),
        .sel_o(sel_o),
        .up_o(up_o),
        .down_o(down_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0] rawq[$];
    logic [2:0] winq[$];
    logic [2:0] m_stable, m_st1, m_st2;
    bit         m_edit;
    int         m_sel, m_presc, m_tmo;
    bit         m_tick;
    int         m_up, m_down;

    task automatic model_reset();
        rawq.delete();
        winq.delete();
        for (int i = 0; i < DB; i++) winq.push_back(3'b000);
        m_stable = '0; m_st1 = '0; m_st2 = '0;
        m_edit = 0; m_sel = 0; m_presc = 0; m_tmo = 0;
        m_tick = 0; m_up = 0; m_down = 0;
    endtask

    task automatic model_step(input logic [2:0] raw);
        logic [2:0] pr;
        logic [2:0] syn;
        bit pm, pu, pd, flip;
        pr = m_st1 & ~m_st2;
        pm = pr[0]; pu = pr[1]; pd = pr[2];
        m_up = 0; m_down = 0; m_tick = 0;
        if (!m_edit) begin
            m_tick = (m_presc == TD - 1);
            m_presc = (m_presc + 1) % TD;
            if (pm) begin
                m_edit = 1; m_sel = 0; m_presc = 0; m_tmo = 0;
            end
        end else begin
            m_presc = 0;
            if (pm || pu || pd) m_tmo = 0;
            else if (m_tmo == TO - 1) begin
                m_edit = 0; m_sel = 0; m_tmo = 0;
            end else m_tmo++;
            if (pm) begin
                if (m_sel == NF - 1) begin m_edit = 0; m_sel = 0; end
                else m_sel++;
            end else if (pu && !pd) m_up = 1 << m_sel;
            else if (pd && !pu) m_down = 1 << m_sel;
        end
        rawq.push_back(raw);
        if (rawq.size() > 3) void'(rawq.pop_front());
        syn = (rawq.size() == 3) ? rawq[0] : 3'b000;
        winq.push_back(syn);
        if (winq.size() > DB) void'(winq.pop_front());
        for (int b = 0; b < 3; b++) begin
            flip = 1;
            foreach (winq[i]) if (winq[i][b] == m_stable[b]) flip = 0;
            if (flip) m_stable[b] = ~m_stable[b];
        end
        m_st2 = m_st1;
        m_st1 = m_stable;
    endtask

    // ---------------- cycle driver and monitors ----------------
    int cyc = 0;
    int up_cnt = 0, down_cnt = 0, tick_cnt = 0;
    int last_up = 0, last_down = 0;
    int first_tick = -1, last_tick_cyc = -1, exit_cyc = -1;
    int edit_seen = 0;
    bit prev_edit = 0;

    task automatic step(input logic [2:0] b);
        btn_mode = b[0]; btn_up = b[1]; btn_down = b[2];
        @(posedge clk);
        model_step(b);
        @(negedge clk);
        cyc++;
        chk("tick", 32'(tick_o), 32'(m_tick));
        chk("edit", 32'(edit_o), 32'(m_edit));
        chk("sel", 32'(sel_o), 32'(m_sel));
        chk("up", 32'(up_o), 32'(m_up));
        chk("down", 32'(down_o), 32'(m_down));
        if (up_o != 0) begin up_cnt++; last_up = int'(up_o); end
        if (down_o != 0) begin down_cnt++; last_down = int'(down_o); end
        if (tick_o) begin
            tick_cnt++; last_tick_cyc = cyc;
            if (first_tick < 0) first_tick = cyc;
        end
        if (edit_o) edit_seen++;
        if (prev_edit && !edit_o) exit_cyc = cyc;
        prev_edit = edit_o;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000);
    endtask

    task automatic press(input logic [2:0] b);
        for (int i = 0; i < DB + 2; i++) step(b);
        idle(DB + 2);
    endtask

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc = 0; first_tick = -1; edit_seen = 0; prev_edit = 0;
    endtask

    int snap_u, snap_d, snap_t, start, lat;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_edit", 32'(edit_o), 0);
        chk("rst_tick", 32'(tick_o), 0);
        restart();

        // 1: free-running ticks
        idle(30);
        chk("t1_ticks", 32'(tick_cnt), 3);
        chk("t1_first", 32'(first_tick), TD);
        chk("t1_noedit", 32'(edit_seen), 0);

        // 3: enter EDIT, advance to field 2, decrement it
        press(3'b001);
        chk("t3_edit", 32'(edit_o), 1);
        chk("t3_sel0", 32'(sel_o), 0);
        snap_t = tick_cnt;
        press(3'b001);
        press(3'b001);
        chk("t3_sel2", 32'(sel_o), 2);
        snap_d = down_cnt;
        press(3'b100);
        chk("t3_dcnt", 32'(down_cnt - snap_d), 1);
        chk("t3_dval", 32'(last_down), 32'h04);
        chk("t3_frozen", 32'(tick_cnt - snap_t), 0);

        // 2: glitch rejected, long hold gives one pulse at fixed latency
        snap_u = up_cnt;
        for (int i = 0; i < DB - 1; i++) step(3'b010);
        idle(DB + 2);
        chk("t2_glitch", 32'(up_cnt - snap_u), 0);
        start = cyc;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            step(3'b010);
            if (lat < 0 && up_o != 0) lat = cyc - start;
        end
        idle(DB + 2);
        chk("t2_lat", 32'(lat), DB + 3);
        chk("t2_once", 32'(up_cnt - snap_u), 1);
        chk("t2_val", 32'(last_up), 32'h04);

        // back to RUN, then 4: full mode cycle from RUN
        for (int i = 0; i < NF - 2; i++) press(3'b001);
        chk("t4_run0", 32'(edit_o), 0);
        for (int i = 0; i < NF + 1; i++) press(3'b001);
        chk("t4_run", 32'(edit_o), 0);
        chk("t4_sel", 32'(sel_o), 0);
        snap_t = tick_cnt;
        for (int i = 0; i < 3 * TD && tick_cnt == snap_t; i++) idle(1);
        chk("t4_tickgap", 32'(last_tick_cyc - exit_cyc), TD);

        // 5: simultaneous up+down cancel; mode beats up
        press(3'b001);
        snap_u = up_cnt; snap_d = down_cnt;
        press(3'b110);
        chk("t5_cancel_u", 32'(up_cnt - snap_u), 0);
        chk("t5_cancel_d", 32'(down_cnt - snap_d), 0);
        press(3'b011);
        chk("t5_sel", 32'(sel_o), 1);
        chk("t5_noup", 32'(up_cnt - snap_u), 0);

        // 6: timeout, then asynchronous reset mid-debounce
        idle(TO + 5);
        chk("t6_tmo_edit", 32'(edit_o), 0);
        chk("t6_tmo_sel", 32'(sel_o), 0);
        press(3'b001);
        press(3'b001);
        press(3'b001);
        chk("t6_pre_sel", 32'(sel_o), 2);
        step(3'b001);
        step(3'b001);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ar_edit", 32'(edit_o), 0);
        chk("t6_ar_sel", 32'(sel_o), 0);
        chk("t6_ar_up", 32'(up_o), 0);
        chk("t6_ar_down", 32'(down_o), 0);
        chk("t6_ar_tick", 32'(tick_o), 0);
        btn_mode = 1'b0;
        repeat (3) @(posedge clk);
        restart();
        idle(30);
        chk("t6_noedit", 32'(edit_seen), 0);
        chk("t6_first", 32'(first_tick), TD);

        // random button activity
        for (int it = 0; it < 120; it++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            for (int i = 0; i < int'($urandom_range(1, DB + 5)); i++) step(v);
            idle(int'($urandom_range(1, DB + 5)));
            if ($urandom_range(0, 14) == 0) idle(TO + 10);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
